// File: rtl/sha256_params_pkg.sv
// Shared register map, bit positions and FSM state encoding for the
// SHA-256 register-map initiator.
package sha256_params_pkg;

    localparam logic [31:0] ADDR_CTRL         = 32'h0000_0010;
    localparam logic [31:0] ADDR_STATUS       = 32'h0000_0018;
    localparam logic [31:0] ADDR_BLOCK_START  = 32'h0000_0080;
    localparam logic [31:0] ADDR_DIGEST_START = 32'h0000_0100;

    localparam int CTRL_INIT_BIT    = 0;
    localparam int CTRL_NEXT_BIT    = 1;
    localparam int CTRL_MODE_BIT    = 2;
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_VALID_BIT = 1;

    localparam logic MODE_SHA224 = 1'b0;
    localparam logic MODE_SHA256 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_RDY,
        ST_WR_BLK,
        ST_WR_CTRL,
        ST_POLL,
        ST_RD_DIG,
        ST_DONE
    } state_t;

    // Word 0 of a block sits in the most significant 32 bits.
    function automatic logic [31:0] block_word(input logic [511:0] blk, input logic [3:0] idx);
        return blk[32*(15 - int'(idx)) +: 32];
    endfunction

    function automatic logic [31:0] ctrl_word(input logic first, input logic mode);
        logic [31:0] w;
        w = '0;
        w[CTRL_INIT_BIT] = first;
        w[CTRL_NEXT_BIT] = ~first;
        w[CTRL_MODE_BIT] = mode;
        return w;
    endfunction

endpackage

// File: rtl/sha256_reg_initiator.sv
// Bus initiator that loads a message block into the SHA-256 register slave,
// starts the core, waits for completion and reads back the digest.
module sha256_reg_initiator
    import sha256_params_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         blk_mode,
    output logic         digest_valid,
    output logic [255:0] digest,
    output logic         err,
    output logic         reg_req_dv,
    output logic         reg_req_write,
    output logic [31:0]  reg_req_addr,
    output logic [31:0]  reg_req_wdata,
    input  logic         reg_req_hold,
    input  logic [31:0]  reg_rdata,
    input  logic         reg_err
);

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + ADDR_STATUS;
    localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + ADDR_CTRL;
    localparam logic [31:0] BLOCK_ADDR  = BASE_ADDR + ADDR_BLOCK_START;
    localparam logic [31:0] DIGEST_ADDR = BASE_ADDR + ADDR_DIGEST_START;

    state_t         state, state_n;
    logic [3:0]     word_cnt, word_cnt_n, word_nxt;
    logic [PW-1:0]  poll_cnt, poll_cnt_n;
    logic           rd_wait, rd_wait_n;
    logic [511:0]   blk_q;
    logic           first_q, last_q, mode_q;
    logic           cap, err_n;
    logic [255:0]   dig_shift, dig_shift_n;
    logic           req_dv_n, req_write_n;
    logic [31:0]    req_addr_n, req_wdata_n;
    logic           accept, status_hit;
    logic [3:0]     last_dig_idx;

    assign accept       = reg_req_dv & ~reg_req_hold;
    assign word_nxt     = word_cnt + 4'd1;
    assign last_dig_idx = (mode_q == MODE_SHA256) ? 4'd7 : 4'd6;
    // CHK_RDY only needs the core idle; POLL needs the digest published too.
    assign status_hit   = (state == ST_CHK_RDY) ? reg_rdata[STATUS_READY_BIT]
                        : (reg_rdata[STATUS_READY_BIT] & reg_rdata[STATUS_VALID_BIT]);

    always_comb begin
        state_n     = state;
        word_cnt_n  = word_cnt;
        poll_cnt_n  = poll_cnt;
        rd_wait_n   = 1'b0;
        dig_shift_n = dig_shift;
        req_dv_n    = reg_req_dv;
        req_write_n = reg_req_write;
        req_addr_n  = reg_req_addr;
        req_wdata_n = reg_req_wdata;
        err_n       = 1'b0;
        cap         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (blk_valid && blk_ready) begin
                    cap         = 1'b1;
                    poll_cnt_n  = '0;
                    state_n     = ST_CHK_RDY;
                    req_dv_n    = 1'b1;
                    req_write_n = 1'b0;
                    req_addr_n  = STATUS_ADDR;
                end
            end
            ST_CHK_RDY, ST_POLL: begin
                if (rd_wait) begin
                    if (reg_err) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else if (status_hit) begin
                        if (state == ST_CHK_RDY) begin
                            state_n     = ST_WR_BLK;
                            word_cnt_n  = 4'd0;
                            req_dv_n    = 1'b1;
                            req_write_n = 1'b1;
                            req_addr_n  = BLOCK_ADDR;
                            req_wdata_n = block_word(blk_q, 4'd0);
                        end else if (last_q) begin
                            state_n     = ST_RD_DIG;
                            word_cnt_n  = 4'd0;
                            req_dv_n    = 1'b1;
                            req_write_n = 1'b0;
                            req_addr_n  = DIGEST_ADDR;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else if (poll_cnt >= POLL_MAX) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        req_dv_n    = 1'b1;
                        req_write_n = 1'b0;
                        req_addr_n  = STATUS_ADDR;
                    end
                end else if (accept) begin
                    req_dv_n   = 1'b0;
                    rd_wait_n  = 1'b1;
                    poll_cnt_n = poll_cnt + 1'b1;
                end
            end
            ST_WR_BLK: begin
                if (accept) begin
                    if (reg_err) begin
                        err_n    = 1'b1;
                        req_dv_n = 1'b0;
                        state_n  = ST_IDLE;
                    end else if (word_cnt == 4'd15) begin
                        state_n     = ST_WR_CTRL;
                        req_addr_n  = CTRL_ADDR;
                        req_wdata_n = ctrl_word(first_q, mode_q);
                    end else begin
                        word_cnt_n  = word_nxt;
                        req_addr_n  = BLOCK_ADDR + {26'd0, word_nxt, 2'b00};
                        req_wdata_n = block_word(blk_q, word_nxt);
                    end
                end
            end
            ST_WR_CTRL: begin
                if (accept) begin
                    if (reg_err) begin
                        err_n    = 1'b1;
                        req_dv_n = 1'b0;
                        state_n  = ST_IDLE;
                    end else begin
                        state_n     = ST_POLL;
                        poll_cnt_n  = '0;
                        req_write_n = 1'b0;
                        req_addr_n  = STATUS_ADDR;
                    end
                end
            end
            ST_RD_DIG: begin
                if (rd_wait) begin
                    if (reg_err) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        dig_shift_n = {dig_shift[223:0], reg_rdata};
                        if (word_cnt == last_dig_idx) begin
                            state_n = ST_DONE;
                        end else begin
                            word_cnt_n  = word_nxt;
                            req_dv_n    = 1'b1;
                            req_write_n = 1'b0;
                            req_addr_n  = DIGEST_ADDR + {26'd0, word_nxt, 2'b00};
                        end
                    end
                end else if (accept) begin
                    req_dv_n  = 1'b0;
                    rd_wait_n = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // SHA-224 shifts in only seven words, so the low word is forced to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            word_cnt      <= '0;
            poll_cnt      <= '0;
            rd_wait       <= 1'b0;
            blk_q         <= '0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            mode_q        <= 1'b0;
            dig_shift     <= '0;
            blk_ready     <= 1'b0;
            digest_valid  <= 1'b0;
            digest        <= '0;
            err           <= 1'b0;
            reg_req_dv    <= 1'b0;
            reg_req_write <= 1'b0;
            reg_req_addr  <= '0;
            reg_req_wdata <= '0;
        end else begin
            state         <= state_n;
            word_cnt      <= word_cnt_n;
            poll_cnt      <= poll_cnt_n;
            rd_wait       <= rd_wait_n;
            dig_shift     <= dig_shift_n;
            blk_ready     <= (state_n == ST_IDLE);
            digest_valid  <= (state == ST_DONE);
            err           <= err_n;
            reg_req_dv    <= req_dv_n;
            reg_req_write <= req_write_n;
            reg_req_addr  <= req_addr_n;
            reg_req_wdata <= req_wdata_n;
            if (cap) begin
                blk_q   <= blk_data;
                first_q <= blk_first;
                last_q  <= blk_last;
                mode_q  <= blk_mode;
            end
            if (state == ST_DONE) begin
                digest <= (mode_q == MODE_SHA256) ? dig_shift : {dig_shift[223:0], 32'h0};
            end
        end
    end

endmodule
